// File: rtl/rst_seq_map_if.sv
// Signal bundle for rst_seq_map: asynchronous reset/lock inputs and sequenced outputs.
// RST_SEQ_SWRST_EN adds the synchronous software reset request sw_rst.
interface rst_seq_map_if #(
  parameter int NUM_CH = 3
);
  logic              aux_resetn;
  logic              dcm_locked;
`ifdef RST_SEQ_SWRST_EN
  logic              sw_rst;
`endif
  logic [NUM_CH-1:0] ch_aresetn;
  logic              done;
  logic [1:0]        state;

`ifdef RST_SEQ_SWRST_EN
  modport master (output aux_resetn, dcm_locked, sw_rst, input ch_aresetn, done, state);
  modport slave  (input aux_resetn, dcm_locked, sw_rst, output ch_aresetn, done, state);
`else
  modport master (output aux_resetn, dcm_locked, input ch_aresetn, done, state);
  modport slave  (input aux_resetn, dcm_locked, output ch_aresetn, done, state);
`endif
endinterface

// File: rtl/rst_seq_map.sv
// Staggered reset release sequencer: holds all channels in reset until the inputs are clean
// for HOLD_CYCLES, then releases them in order. Optional macro RST_SEQ_SWRST_EN adds sw_rst.
module rst_seq_map #(
  parameter int NUM_CH      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGGER     = 4
) (
  input logic          aclk,
  input logic          aresetn,
  rst_seq_map_if.slave bus
);

  localparam logic [1:0] ST_ASSERT  = 2'b00;
  localparam logic [1:0] ST_RELEASE = 2'b01;
  localparam logic [1:0] ST_RUN     = 2'b10;

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int SW = $clog2(STAGGER + 1);

  localparam logic [HW-1:0]     HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0]     HOLD_SAT  = HW'(HOLD_CYCLES);
  localparam logic [SW-1:0]     STAG_LAST = SW'(STAGGER - 1);
  localparam logic [NUM_CH-1:0] ALL_ON    = '1;
  localparam logic [NUM_CH-1:0] FIRST_CH  = NUM_CH'(1);

  logic [SYNC_STAGES-1:0] aux_sync_q, aux_sync_d;
  logic [SYNC_STAGES-1:0] dcm_sync_q, dcm_sync_d;
  logic [1:0]             state_q, state_d;
  logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
  logic [SW-1:0]          stag_cnt_q, stag_cnt_d;
  logic [NUM_CH-1:0]      ch_q, ch_d;
  logic                   done_q, done_d;
  logic [NUM_CH-1:0]      ch_next;
  logic                   fault;

`ifdef RST_SEQ_SWRST_EN
  assign fault = ~aux_sync_q[SYNC_STAGES-1] | ~dcm_sync_q[SYNC_STAGES-1] | bus.sw_rst;
`else
  assign fault = ~aux_sync_q[SYNC_STAGES-1] | ~dcm_sync_q[SYNC_STAGES-1];
`endif

  // Channels release as a thermometer code: bit 0 first, each step adds the next bit up.
  assign ch_next = (ch_q << 1) | FIRST_CH;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    stag_cnt_d = stag_cnt_q;
    ch_d       = ch_q;
    done_d     = done_q;
    aux_sync_d = {aux_sync_q[SYNC_STAGES-2:0], bus.aux_resetn};
    dcm_sync_d = {dcm_sync_q[SYNC_STAGES-2:0], bus.dcm_locked};

    case (state_q)
      ST_ASSERT: begin
        ch_d       = '0;
        done_d     = 1'b0;
        stag_cnt_d = '0;
        if (fault) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q >= HOLD_LAST) begin
          hold_cnt_d = HOLD_SAT;
          ch_d       = FIRST_CH;
          done_d     = (FIRST_CH == ALL_ON);
          state_d    = (FIRST_CH == ALL_ON) ? ST_RUN : ST_RELEASE;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      ST_RELEASE, ST_RUN: begin
        if (fault) begin
          state_d    = ST_ASSERT;
          hold_cnt_d = '0;
          stag_cnt_d = '0;
          ch_d       = '0;
          done_d     = 1'b0;
        end else if (state_q == ST_RELEASE) begin
          if (stag_cnt_q >= STAG_LAST) begin
            stag_cnt_d = '0;
            ch_d       = ch_next;
            if (ch_next == ALL_ON) begin
              done_d  = 1'b1;
              state_d = ST_RUN;
            end
          end else begin
            stag_cnt_d = stag_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d    = ST_ASSERT;
        hold_cnt_d = '0;
        stag_cnt_d = '0;
        ch_d       = '0;
        done_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!aresetn) begin
      // NOTE: synchronizer flops are reset too, so a reset always restarts the full clean-input count.
      aux_sync_q <= '0;
      dcm_sync_q <= '0;
      state_q    <= ST_ASSERT;
      hold_cnt_q <= '0;
      stag_cnt_q <= '0;
      ch_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      aux_sync_q <= aux_sync_d;
      dcm_sync_q <= dcm_sync_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      stag_cnt_q <= stag_cnt_d;
      ch_q       <= ch_d;
      done_q     <= done_d;
    end
  end

  assign bus.ch_aresetn = ch_q;
  assign bus.done       = done_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_rst_seq_map.sv
// Scoreboard bench for rst_seq_map: a 3-channel default instance and a 1-channel instance.
// Expected output snapshots are queued per edge number and compared as each edge is reached.
module tb_rst_seq_map;

  logic aclk = 1'b0;
  logic aresetn;

  always #5 aclk = ~aclk;

  rst_seq_map_if #(.NUM_CH(3)) bus  ();
  rst_seq_map_if #(.NUM_CH(1)) bus1 ();

  rst_seq_map #(.NUM_CH(3), .SYNC_STAGES(2), .HOLD_CYCLES(16), .STAGGER(4)) u_dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  rst_seq_map #(.NUM_CH(1), .SYNC_STAGES(2), .HOLD_CYCLES(1), .STAGGER(4)) u_one (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus1)
  );

  typedef struct {
    int         edge_no;
    int         dut;
    logic [7:0] ch;
    logic       done;
    logic [1:0] st;
  } exp_t;

  exp_t  sb[$];
  int    total = 0;
  int    bad   = 0;
  int    ecount = 0;
  string cur_test = "";

  task automatic expect_at(input int e, input int d, input logic [7:0] ch,
                           input logic dn, input logic [1:0] st);
    exp_t x;
    x.edge_no = e;
    x.dut     = d;
    x.ch      = ch;
    x.done    = dn;
    x.st      = st;
    sb.push_back(x);
  endtask

  // One rising edge, then compare every expectation due at or before this edge.
  task automatic step();
    exp_t       x;
    logic [7:0] oc;
    logic       od;
    logic [1:0] os;
    @(posedge aclk);
    ecount++;
    #1;
    while (sb.size() > 0 && sb[0].edge_no <= ecount) begin
      x = sb.pop_front();
      if (x.dut == 0) begin
        oc = {5'b0, bus.ch_aresetn};
        od = bus.done;
        os = bus.state;
      end else begin
        oc = {7'b0, bus1.ch_aresetn};
        od = bus1.done;
        os = bus1.state;
      end
      total++;
      if ({oc, od, os} !== {x.ch, x.done, x.st}) begin
        bad++;
        $display("FAIL %s edge %0d dut%0d: got ch=%b done=%b state=%b, want ch=%b done=%b state=%b",
                 cur_test, ecount, x.dut, oc, od, os, x.ch, x.done, x.st);
      end
    end
  endtask

  task automatic run_edges(input int n);
    repeat (n) step();
  endtask

  // Any expectation never reached within the scenario's edge budget counts as a failure.
  task automatic finish_scenario();
    exp_t x;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      total++;
      bad++;
      $display("FAIL %s edge %0d dut%0d: not reached (stopped at edge %0d)",
               cur_test, x.edge_no, x.dut, ecount);
    end
  endtask

  // Holds reset for a few edges, then releases so that the next rising edge is edge 1.
  task automatic begin_run();
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    ecount  = 0;
  endtask

  task automatic test_reset();
    cur_test = "reset";
    aresetn  = 1'b0;
    ecount   = 0;
    expect_at(1, 0, 8'b000, 1'b0, 2'b00);
    expect_at(1, 1, 8'b0,   1'b0, 2'b00);
    expect_at(2, 0, 8'b000, 1'b0, 2'b00);
    expect_at(2, 1, 8'b0,   1'b0, 2'b00);
    run_edges(2);
    finish_scenario();
  endtask

  task automatic test_power_up();
    cur_test = "power_up";
    begin_run();
    expect_at(17, 0, 8'b000, 1'b0, 2'b00);
    expect_at(18, 0, 8'b001, 1'b0, 2'b01);
    expect_at(21, 0, 8'b001, 1'b0, 2'b01);
    expect_at(22, 0, 8'b011, 1'b0, 2'b01);
    expect_at(25, 0, 8'b011, 1'b0, 2'b01);
    expect_at(26, 0, 8'b111, 1'b1, 2'b10);
    expect_at(30, 0, 8'b111, 1'b1, 2'b10);
    run_edges(30);
    finish_scenario();
  endtask

  task automatic test_aux_glitch();
    cur_test = "aux_glitch";
    begin_run();
    expect_at(18, 0, 8'b000, 1'b0, 2'b00);
    expect_at(27, 0, 8'b000, 1'b0, 2'b00);
    expect_at(28, 0, 8'b001, 1'b0, 2'b01);
    expect_at(32, 0, 8'b011, 1'b0, 2'b01);
    expect_at(36, 0, 8'b111, 1'b1, 2'b10);
    run_edges(9);
    bus.aux_resetn = 1'b0;
    run_edges(1);
    bus.aux_resetn = 1'b1;
    run_edges(26);
    finish_scenario();
  endtask

  task automatic test_lock_loss();
    cur_test = "lock_loss";
    begin_run();
    expect_at(26, 0, 8'b111, 1'b1, 2'b10);
    expect_at(32, 0, 8'b111, 1'b1, 2'b10);
    expect_at(33, 0, 8'b000, 1'b0, 2'b00);
    expect_at(52, 0, 8'b000, 1'b0, 2'b00);
    expect_at(53, 0, 8'b001, 1'b0, 2'b01);
    expect_at(61, 0, 8'b111, 1'b1, 2'b10);
    run_edges(30);
    bus.dcm_locked = 1'b0;
    run_edges(5);
    bus.dcm_locked = 1'b1;
    run_edges(26);
    finish_scenario();
  endtask

  task automatic test_reset_mid_release();
    cur_test = "reset_mid_release";
    begin_run();
    expect_at(23, 0, 8'b011, 1'b0, 2'b01);
    expect_at(24, 0, 8'b000, 1'b0, 2'b00);
    expect_at(26, 0, 8'b000, 1'b0, 2'b00);
    expect_at(43, 0, 8'b000, 1'b0, 2'b00);
    expect_at(44, 0, 8'b001, 1'b0, 2'b01);
    run_edges(23);
    aresetn = 1'b0;
    run_edges(3);
    aresetn = 1'b1;
    run_edges(18);
    finish_scenario();
  endtask

  task automatic test_single_channel();
    cur_test = "single_channel";
    begin_run();
    expect_at(1, 1, 8'b0, 1'b0, 2'b00);
    expect_at(2, 1, 8'b0, 1'b0, 2'b00);
    expect_at(3, 1, 8'b1, 1'b1, 2'b10);
    expect_at(5, 1, 8'b1, 1'b1, 2'b10);
    run_edges(5);
    finish_scenario();
  endtask

`ifdef RST_SEQ_SWRST_EN
  task automatic test_sw_rst();
    cur_test = "sw_rst";
    begin_run();
    expect_at(28, 0, 8'b111, 1'b1, 2'b10);
    expect_at(29, 0, 8'b000, 1'b0, 2'b00);
    expect_at(44, 0, 8'b000, 1'b0, 2'b00);
    expect_at(45, 0, 8'b001, 1'b0, 2'b01);
    run_edges(28);
    bus.sw_rst = 1'b1;
    run_edges(1);
    bus.sw_rst = 1'b0;
    run_edges(16);
    finish_scenario();
  endtask
`endif

  initial begin
    aresetn         = 1'b0;
    bus.aux_resetn  = 1'b1;
    bus.dcm_locked  = 1'b1;
    bus1.aux_resetn = 1'b1;
    bus1.dcm_locked = 1'b1;
`ifdef RST_SEQ_SWRST_EN
    bus.sw_rst      = 1'b0;
    bus1.sw_rst     = 1'b0;
`endif
    test_reset();
    test_power_up();
    test_aux_glitch();
    test_lock_loss();
    test_reset_mid_release();
    test_single_channel();
`ifdef RST_SEQ_SWRST_EN
    test_sw_rst();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rst_seq_map.md
RST_SEQ_MAP -- requirements
Module: rst_seq_map

Interface
REQ-001 Parameter NUM_CH, 3, number of reset channels released in order; legal range 1..8.
REQ-002 Parameter SYNC_STAGES, 2, synchronizer depth for aux_resetn and dcm_locked; legal range 2..4.
REQ-003 Parameter HOLD_CYCLES, 16, minimum clean-input cycles before the first channel is released; legal range 1..1024.
REQ-004 Parameter STAGGER, 4, cycles between consecutive channel releases; legal range 1..255.
REQ-005 Port aclk input 1: the single clock; all logic is on its rising edge.
REQ-006 Port aresetn input 1: reset, synchronous and active-low.
REQ-007 Port aux_resetn input 1: external reset request, active-low, asynchronous to aclk.
REQ-008 Port dcm_locked input 1: clock-source lock indication, asynchronous to aclk.
REQ-009 Port ch_aresetn output NUM_CH: per-channel active-low interconnect reset; bit 0 is released first.
REQ-010 Port done output 1: high while every channel is released.
REQ-011 Port state output 2: current FSM state encoding (00 ASSERT, 01 RELEASE, 10 RUN) for debug.

Function
REQ-012 aux_resetn and dcm_locked SHALL each pass through a SYNC_STAGES-flop synchronizer; every flop resets to 0.
REQ-013 fault SHALL be the OR of (not synced aux_resetn) and (not synced dcm_locked), evaluated from the final synchronizer stages.
REQ-014 ASSERT: all ch_aresetn = 0 and done = 0; hold_cnt increments on each cycle with fault = 0 and clears to 0 on any cycle with fault = 1.
REQ-015 ASSERT to RELEASE: on the edge where hold_cnt reaches HOLD_CYCLES, ch_aresetn[0] SHALL go to 1 on that same edge and stag_cnt SHALL clear.
REQ-016 RELEASE: every STAGGER cycles the next channel index in ascending order is set to 1; released channels stay 1.
REQ-017 RELEASE to RUN: on the edge that releases channel NUM_CH-1, done SHALL go to 1 on that same edge.
REQ-018 With NUM_CH = 1, the FSM SHALL go directly from ASSERT to RUN, with ch_aresetn[0] and done rising on the same edge.
REQ-019 Timing: after both inputs settle high, ch_aresetn[k] SHALL rise exactly SYNC_STAGES + HOLD_CYCLES + k*STAGGER edges after the first high sample.
REQ-020 fault = 1 in RELEASE or RUN SHALL return the FSM to ASSERT on the next edge; that edge drives all ch_aresetn and done to 0 simultaneously and clears hold_cnt.
REQ-021 A fault lasting a single cycle SHALL still cause a full re-sequence from hold_cnt = 0.
REQ-022 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-023 Counter widths SHALL be clog2(HOLD_CYCLES+1) for hold_cnt and clog2(STAGGER+1) for stag_cnt; counters SHALL saturate and never wrap.

Reset
REQ-024 With aresetn = 0 on a rising edge, the block SHALL enter ASSERT with hold_cnt = 0, stag_cnt = 0, all synchronizer flops = 0, ch_aresetn = 0, done = 0, and state = 00.
REQ-025 aresetn = 0 in any state, including mid-RELEASE, SHALL take priority over all other inputs.
REQ-026 After aresetn goes high, timing SHALL follow REQ-019 from the first edge at which the inputs are sampled high.

Configuration
REQ-027 Macro RST_SEQ_SWRST_EN, when defined, SHALL add input sw_rst (1 bit, synchronous to aclk, active-high) and OR it into fault without synchronization.
REQ-028 With RST_SEQ_SWRST_EN defined, a one-cycle sw_rst pulse in RUN SHALL clear all channels on the next edge and restart the HOLD_CYCLES count.
REQ-029 With RST_SEQ_SWRST_EN undefined, the sw_rst port SHALL be absent and behaviour SHALL be identical to REQ-012 through REQ-026.

Verification
REQ-030 Defaults, aresetn released, inputs high from cycle 0 -> ch_aresetn[0] rises at edge 18, [1] at edge 22, [2] at edge 26; done rises at edge 26.
REQ-031 Defaults, aux_resetn pulsed low for 1 cycle at edge 10 -> hold restarts; ch_aresetn[0] rises 18 edges after aux_resetn returns high.
REQ-032 RUN, dcm_locked dropped -> ch_aresetn = 000 and done = 0 exactly SYNC_STAGES+1 edges later; full re-sequence follows once lock returns.
REQ-033 aresetn driven low at edge 23 (ch0 and ch1 released) -> at edge 24, ch_aresetn = 000, state = 00, done = 0.
REQ-034 NUM_CH = 1, HOLD_CYCLES = 1, SYNC_STAGES = 2 -> ch_aresetn[0] and done rise together at edge 3; state goes 00 to 10.
REQ-035 RST_SEQ_SWRST_EN defined, sw_rst pulsed for 1 cycle in RUN -> all channels clear on the next edge; ch_aresetn[0] rises again after 16 further edges.
